// File: rtl/div_unit_pkg.sv
// Shared widths and encodings for the multi-cycle divider.
package div_unit_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned CntW         = 6;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] cond_neg(input logic neg, input logic [RegBus-1:0] v);
    return neg ? (RegBus'(0) - v) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: trial subtract of the divisor from the partial remainder.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [DoubleRegBus-1:0] work_i,
  input  logic [RegBus-1:0]       divisor_i,
  output logic [DoubleRegBus:0]   work_o
);

  logic [RegBus:0] diff;

  always_comb begin
    diff = {1'b0, work_i[DoubleRegBus-1:RegBus]} - {1'b0, divisor_i};
    if (!diff[RegBus]) begin
      work_o = {diff[RegBus-1:0], work_i[RegBus-1:0], 1'b1};
    end else begin
      work_o = {work_i, 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU: 32 restoring steps, result held until EX drops start.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DoubleRegBus:0]   work_q, work_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    neg_quot_q, neg_quot_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [DoubleRegBus:0]   step_work;
  logic [RegBus-1:0]       abs_dividend, abs_divisor;
  logic [RegBus-1:0]       quot_raw, rem_raw;

  // The top bit only ever receives the shifted-out remainder MSB; it is never read back.
  logic unused_work_msb;
  assign unused_work_msb = work_q[DoubleRegBus];

  div_unit_step u_step (
    .work_i    (work_q[DoubleRegBus-1:0]),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  assign abs_dividend = cond_neg(signed_div_i & opdata1_i[RegBus-1], opdata1_i);
  assign abs_divisor  = cond_neg(signed_div_i & opdata2_i[RegBus-1], opdata2_i);
  assign quot_raw     = step_work[RegBus-1:0];
  assign rem_raw      = step_work[DoubleRegBus:RegBus+1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            work_d     = {{RegBus{1'b0}}, abs_dividend, 1'b0};
            divisor_d  = abs_divisor;
            neg_quot_d = signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
            neg_rem_d  = signed_div_i & opdata1_i[RegBus-1];
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        // Annul beats completion, even on the final step.
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
          ready_d = DivResultNotReady;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntW'(RegBus - 1)) begin
            state_d  = DivEnd;
            result_d = {cond_neg(neg_rem_q, rem_raw), cond_neg(neg_quot_q, quot_raw)};
            ready_d  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
